// File: rtl/reg_demux4.sv
// Registered 1-to-4 demultiplexer: each accepted word lands in a one-entry register
// on the channel chosen by Select, with an independent valid/ready handshake per channel.
module reg_demux4 #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int BUS_WIDTH       = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [INPUT_BIT_WIDTH-1:0] Input,
    input  logic [BUS_WIDTH-1:0]       Select,
    input  logic                       InputValid,
    output logic                       InputReady,
    output logic [INPUT_BIT_WIDTH-1:0] OutputA,
    output logic [INPUT_BIT_WIDTH-1:0] OutputB,
    output logic [INPUT_BIT_WIDTH-1:0] OutputC,
    output logic [INPUT_BIT_WIDTH-1:0] OutputD,
    output logic                       ValidA,
    output logic                       ValidB,
    output logic                       ValidC,
    output logic                       ValidD,
    input  logic                       ReadyA,
    input  logic                       ReadyB,
    input  logic                       ReadyC,
    input  logic                       ReadyD,
    output logic [3:0]                 Pending,
    output logic [15:0]                AcceptCount
);

    logic [INPUT_BIT_WIDTH-1:0] data_q [4];
    logic [INPUT_BIT_WIDTH-1:0] data_d [4];
    logic [3:0]                 valid_q, valid_d;
    logic [15:0]                count_q, count_d;
    logic [3:0]                 ready_vec;
    logic                       accept;

    assign ready_vec = {ReadyD, ReadyC, ReadyB, ReadyA};

    // Only the selected channel decides acceptance; InputValid never feeds back into it.
    assign InputReady = !valid_q[Select] || ready_vec[Select];
    assign accept     = InputValid && InputReady;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ready_vec;
        count_d = count_q;
        // A drain and an accept on the same channel merge: the new word replaces it with no bubble.
        if (accept) begin
            data_d[Select]  = Input;
            valid_d[Select] = 1'b1;
            count_d         = count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign OutputA     = data_q[0];
    assign OutputB     = data_q[1];
    assign OutputC     = data_q[2];
    assign OutputD     = data_q[3];
    assign ValidA      = valid_q[0];
    assign ValidB      = valid_q[1];
    assign ValidC      = valid_q[2];
    assign ValidD      = valid_q[3];
    assign Pending     = valid_q;
    assign AcceptCount = count_q;

endmodule

// File: tb/tb_reg_demux4.sv
// Bench for reg_demux4: vector table plus hand sequences, with a per-channel delivery scoreboard.
module tb_reg_demux4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  Input;
    logic [1:0]  Select;
    logic        InputValid;
    logic        InputReady;
    logic [7:0]  OutputA, OutputB, OutputC, OutputD;
    logic        ValidA, ValidB, ValidC, ValidD;
    logic        ReadyA, ReadyB, ReadyC, ReadyD;
    logic [3:0]  Pending;
    logic [15:0] AcceptCount;

    logic [31:0] outs_w;
    logic [3:0]  valid_w;
    assign outs_w  = {OutputD, OutputC, OutputB, OutputA};
    assign valid_w = {ValidD, ValidC, ValidB, ValidA};

    int checks   = 0;
    int failures = 0;

    reg_demux4 #(.INPUT_BIT_WIDTH(8), .BUS_WIDTH(2)) dut (
        .Clk(Clk), .Reset(Reset), .Input(Input), .Select(Select),
        .InputValid(InputValid), .InputReady(InputReady),
        .OutputA(OutputA), .OutputB(OutputB), .OutputC(OutputC), .OutputD(OutputD),
        .ValidA(ValidA), .ValidB(ValidB), .ValidC(ValidC), .ValidD(ValidD),
        .ReadyA(ReadyA), .ReadyB(ReadyB), .ReadyC(ReadyC), .ReadyD(ReadyD),
        .Pending(Pending), .AcceptCount(AcceptCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  din;
        logic [1:0]  sel;
        logic        iv;
        logic [3:0]  rdy;
        logic        ir;
        logic [3:0]  pend;
        logic [15:0] cnt;
        logic [31:0] outs;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] d;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    function automatic vec_t mk(input logic [7:0] din, input logic [1:0] sel, input logic iv,
                                input logic [3:0] rdy, input logic ir, input logic [3:0] pend,
                                input logic [15:0] cnt, input logic [31:0] outs);
        vec_t v;
        v.din = din; v.sel = sel; v.iv = iv; v.rdy = rdy;
        v.ir = ir; v.pend = pend; v.cnt = cnt; v.outs = outs;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic [7:0] din, input logic [1:0] sel, input logic iv,
                         input logic [3:0] rdy);
        Input = din; Select = sel; InputValid = iv;
        {ReadyD, ReadyC, ReadyB, ReadyA} = rdy;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        bit found;
        drive(v.din, v.sel, v.iv, v.rdy);
        #1;
        chk({tag, " InputReady"}, {31'd0, InputReady}, {31'd0, v.ir});
        for (int n = 0; n < 4; n++) begin
            if (valid_w[n] && v.rdy[n]) begin
                found = 1'b0;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (!found && sbq[i].ch == n[1:0]) begin
                        found = 1'b1;
                        chk($sformatf("%s deliver ch%0d", tag, n), {24'd0, outs_w[n*8 +: 8]},
                            {24'd0, sbq[i].d});
                        sbq.delete(i);
                    end
                end
                if (!found) begin
                    checks++;
                    failures++;
                    $display("FAIL %s deliver ch%0d actual=unexpected word required=none", tag, n);
                end
            end
        end
        if (v.iv && v.ir) sbq.push_back('{ch: v.sel, d: v.din});
        @(posedge Clk);
        @(negedge Clk);
        chk({tag, " Pending"}, {28'd0, Pending}, {28'd0, v.pend});
        chk({tag, " AcceptCount"}, {16'd0, AcceptCount}, {16'd0, v.cnt});
        chk({tag, " Outputs"}, outs_w, v.outs);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " Pending"}, {28'd0, Pending}, 32'd0);
        chk({tag, " Valid"}, {28'd0, valid_w}, 32'd0);
        chk({tag, " Outputs"}, outs_w, 32'd0);
        chk({tag, " AcceptCount"}, {16'd0, AcceptCount}, 32'd0);
    endtask

    initial begin
        Reset = 1'b0;
        drive(8'd0, 2'd0, 1'b0, 4'b0000);
        repeat (2) @(negedge Clk);
        reset_checks("reset");
        Reset = 1'b1;

        // Outputs packed {D,C,B,A}; ready/pending packed {D,C,B,A}.
        tbl.push_back(mk(8'd42, 2'd0, 1, 4'b1111, 1, 4'b0001, 16'd1,  {8'd0, 8'd0, 8'd0,  8'd42}));
        tbl.push_back(mk(8'd15, 2'd1, 1, 4'b1111, 1, 4'b0010, 16'd2,  {8'd0, 8'd0, 8'd15, 8'd42}));
        tbl.push_back(mk(8'd2,  2'd2, 1, 4'b1111, 1, 4'b0100, 16'd3,  {8'd0, 8'd2, 8'd15, 8'd42}));
        tbl.push_back(mk(8'd0,  2'd3, 1, 4'b1111, 1, 4'b1000, 16'd4,  {8'd0, 8'd2, 8'd15, 8'd42}));
        tbl.push_back(mk(8'd0,  2'd0, 0, 4'b1111, 1, 4'b0000, 16'd4,  {8'd0, 8'd2, 8'd15, 8'd42}));
        // B stalled: second word waits, A still flows
        tbl.push_back(mk(8'd15, 2'd1, 1, 4'b1101, 1, 4'b0010, 16'd5,  {8'd0, 8'd2, 8'd15, 8'd42}));
        tbl.push_back(mk(8'd99, 2'd1, 1, 4'b1101, 0, 4'b0010, 16'd5,  {8'd0, 8'd2, 8'd15, 8'd42}));
        tbl.push_back(mk(8'd99, 2'd1, 1, 4'b1101, 0, 4'b0010, 16'd5,  {8'd0, 8'd2, 8'd15, 8'd42}));
        tbl.push_back(mk(8'd7,  2'd0, 1, 4'b1101, 1, 4'b0011, 16'd6,  {8'd0, 8'd2, 8'd15, 8'd7}));
        tbl.push_back(mk(8'd99, 2'd1, 1, 4'b1111, 1, 4'b0010, 16'd7,  {8'd0, 8'd2, 8'd99, 8'd7}));
        tbl.push_back(mk(8'd0,  2'd1, 0, 4'b1111, 1, 4'b0000, 16'd7,  {8'd0, 8'd2, 8'd99, 8'd7}));
        // Select changes while idle/stalled have no side effects
        tbl.push_back(mk(8'd5,  2'd1, 1, 4'b1101, 1, 4'b0010, 16'd8,  {8'd0, 8'd2, 8'd5,  8'd7}));
        tbl.push_back(mk(8'd77, 2'd1, 0, 4'b1101, 0, 4'b0010, 16'd8,  {8'd0, 8'd2, 8'd5,  8'd7}));
        tbl.push_back(mk(8'd88, 2'd2, 0, 4'b1101, 1, 4'b0010, 16'd8,  {8'd0, 8'd2, 8'd5,  8'd7}));
        tbl.push_back(mk(8'd0,  2'd1, 0, 4'b1111, 1, 4'b0000, 16'd8,  {8'd0, 8'd2, 8'd5,  8'd7}));
        // Back-to-back stream to C
        tbl.push_back(mk(8'd1,  2'd2, 1, 4'b1111, 1, 4'b0100, 16'd9,  {8'd0, 8'd1, 8'd5,  8'd7}));
        tbl.push_back(mk(8'd2,  2'd2, 1, 4'b1111, 1, 4'b0100, 16'd10, {8'd0, 8'd2, 8'd5,  8'd7}));
        tbl.push_back(mk(8'd3,  2'd2, 1, 4'b1111, 1, 4'b0100, 16'd11, {8'd0, 8'd3, 8'd5,  8'd7}));
        tbl.push_back(mk(8'd4,  2'd2, 1, 4'b1111, 1, 4'b0100, 16'd12, {8'd0, 8'd4, 8'd5,  8'd7}));
        tbl.push_back(mk(8'd0,  2'd2, 0, 4'b1111, 1, 4'b0000, 16'd12, {8'd0, 8'd4, 8'd5,  8'd7}));
        // A and D fill, then drain together
        tbl.push_back(mk(8'd11, 2'd0, 1, 4'b0110, 1, 4'b0001, 16'd13, {8'd0,  8'd4, 8'd5, 8'd11}));
        tbl.push_back(mk(8'd22, 2'd3, 1, 4'b0110, 1, 4'b1001, 16'd14, {8'd22, 8'd4, 8'd5, 8'd11}));
        tbl.push_back(mk(8'd33, 2'd0, 1, 4'b0110, 0, 4'b1001, 16'd14, {8'd22, 8'd4, 8'd5, 8'd11}));
        tbl.push_back(mk(8'd0,  2'd0, 0, 4'b1111, 1, 4'b0000, 16'd14, {8'd22, 8'd4, 8'd5, 8'd11}));
        tbl.push_back(mk(8'd44, 2'd0, 1, 4'b0110, 1, 4'b0001, 16'd15, {8'd22, 8'd4, 8'd5, 8'd44}));
        tbl.push_back(mk(8'd55, 2'd3, 1, 4'b0110, 1, 4'b1001, 16'd16, {8'd55, 8'd4, 8'd5, 8'd44}));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

        // Reset with A and D full and an offered word: everything discarded
        Reset = 1'b0;
        drive(8'd66, 2'd1, 1'b1, 4'b1111);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        sbq.delete();
        reset_checks("midreset");
        apply(mk(8'd66, 2'd1, 1, 4'b1111, 1, 4'b0010, 16'd1, {8'd0, 8'd0, 8'd66, 8'd0}), "postreset0");
        apply(mk(8'd0,  2'd1, 0, 4'b1111, 1, 4'b0000, 16'd1, {8'd0, 8'd0, 8'd66, 8'd0}), "postreset1");

        // Stream to A until the counter sits at its maximum
        for (int i = 0; i < 65534; i++) begin
            drive(i[7:0], 2'd0, 1'b1, 4'b1111);
            @(negedge Clk);
        end
        drive(8'd0, 2'd0, 1'b0, 4'b1111);
        @(negedge Clk);
        chk("count max", {16'd0, AcceptCount}, 32'd65535);
        chk("count max Pending", {28'd0, Pending}, 32'd0);
        apply(mk(8'hA5, 2'd0, 1, 4'b1111, 1, 4'b0001, 16'd0, {8'd0, 8'd0, 8'd66, 8'hA5}), "wrap0");
        apply(mk(8'd0,  2'd0, 0, 4'b1111, 1, 4'b0000, 16'd0, {8'd0, 8'd0, 8'd66, 8'hA5}), "wrap1");

        chk("scoreboard empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
